// File: rtl/mem_data_arb_pkg.sv
// Shared widths and arbitration state type for mem_data_arb and the
// single-port data memory it drives.
package mem_data_arb_pkg;
  localparam int ADDR = 8;
  localparam int WORD = 16;
  localparam int LEN  = 1 << ADDR;

  typedef enum logic {
    NORMAL   = 1'b0,
    ESCALATE = 1'b1
  } arb_state_e;
endpackage

// File: rtl/mem_data.sv
// Single-port synchronous data memory: registered read, Q holds its
// previous value during a write cycle.
module mem_data
  import mem_data_arb_pkg::*;
#(
  parameter int AW = ADDR,
  parameter int DW = WORD
) (
  input  logic          clk,
  input  logic [AW-1:0] A,
  input  logic          W,
  input  logic [DW-1:0] D,
  output logic [DW-1:0] Q
);

  logic [DW-1:0] mem_q [LEN];
  logic [DW-1:0] q_q;

  always_ff @(posedge clk) begin
    if (W) begin
      mem_q[A] <= D;
    end else begin
      q_q <= mem_q[A];
    end
  end

  assign Q = q_q;

endmodule

// File: rtl/mem_data_arb.sv
// Two-port arbiter for mem_data: port 0 has priority, port 1 is forced
// through after STARVE_LIM consecutive refused cycles.
module mem_data_arb
  import mem_data_arb_pkg::*;
#(
  parameter int STARVE_LIM = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0,
  input  logic            we0,
  input  logic [ADDR-1:0] addr0,
  input  logic [WORD-1:0] wdata0,
  input  logic            req1,
  input  logic            we1,
  input  logic [ADDR-1:0] addr1,
  input  logic [WORD-1:0] wdata1,
  output logic            ack0,
  output logic            ack1,
  output logic            rvalid0,
  output logic            rvalid1,
  output logic [WORD-1:0] rdata0,
  output logic [WORD-1:0] rdata1,
  output logic [ADDR-1:0] mem_A,
  output logic            mem_W,
  output logic [WORD-1:0] mem_D,
  input  logic [WORD-1:0] mem_Q
);

  localparam logic [7:0] LIM = 8'(STARVE_LIM);

  arb_state_e state_q, state_d;
  logic [7:0] starve_cnt_q, starve_cnt_d;
  logic       rvalid0_q, rvalid0_d;
  logic       rvalid1_q, rvalid1_d;
  logic       grant0, grant1;

  always_comb begin
    grant1 = req1 && (!req0 || (state_q == ESCALATE));
    grant0 = req0 && !grant1;
    // Reset forces the memory side idle even though the inputs may be live.
    ack0   = grant0 && !rst;
    ack1   = grant1 && !rst;

    mem_A = '0;
    mem_W = 1'b0;
    mem_D = '0;
    if (ack0) begin
      mem_A = addr0;
      mem_W = we0;
      mem_D = wdata0;
    end else if (ack1) begin
      mem_A = addr1;
      mem_W = we1;
      mem_D = wdata1;
    end

    if (!req1 || ack1) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q < LIM) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end else begin
      starve_cnt_d = starve_cnt_q;
    end

    state_d = state_q;
    case (state_q)
      NORMAL:   if (starve_cnt_d == LIM) state_d = ESCALATE;
      ESCALATE: if (ack0 || ack1) state_d = NORMAL;
      default:  state_d = NORMAL;
    endcase

    rvalid0_d = ack0 && !we0;
    rvalid1_d = ack1 && !we1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= NORMAL;
      starve_cnt_q <= '0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = mem_Q;
  assign rdata1  = mem_Q;

endmodule
